// File: rtl/rs_age_arbiter.sv
// Purpose: merges N reservation-station channels into one execution port, oldest (wrap-aware) first.
// Latency: one cycle from acceptance to out_valid_o through a 2-entry registered skid queue.
// Backpressure: in_ready_o depends only on queue occupancy, flush and reset, never on out_ready_o.
module rs_age_arbiter #(
  parameter int CHANNELS    = 3,
  parameter int RS_ID_WIDTH = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 16,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [RS_ID_WIDTH-1:0]          head_id_i,
  input  logic                            flush_i,
  input  logic [CHANNELS-1:0]             in_valid_i,
  output logic [CHANNELS-1:0]             in_ready_o,
  input  logic [CHANNELS*RS_ID_WIDTH-1:0] in_rs_id_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0]  in_data_i,
  input  logic [CHANNELS*CTRL_WIDTH-1:0]  in_ctrl_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [RS_ID_WIDTH-1:0]          out_rs_id_o,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic [CTRL_WIDTH-1:0]           out_ctrl_o,
  output logic [CH_W-1:0]                 out_channel_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                 state_q;

  // Head entry drives the outputs directly; the skid entry holds the second-oldest push.
  logic                   out_valid_q;
  logic [RS_ID_WIDTH-1:0] head_rs_id_q;
  logic [DATA_WIDTH-1:0]  head_data_q;
  logic [CTRL_WIDTH-1:0]  head_ctrl_q;
  logic [CH_W-1:0]        head_channel_q;
  logic [RS_ID_WIDTH-1:0] skid_rs_id_q;
  logic [DATA_WIDTH-1:0]  skid_data_q;
  logic [CTRL_WIDTH-1:0]  skid_ctrl_q;
  logic [CH_W-1:0]        skid_channel_q;

  // Winner of the current cycle's selection.
  logic [RS_ID_WIDTH-1:0] age [CHANNELS];
  logic                   sel_any;
  logic [CH_W-1:0]        sel_idx;
  logic [RS_ID_WIDTH-1:0] sel_age;
  logic [RS_ID_WIDTH-1:0] sel_rs_id;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [CTRL_WIDTH-1:0]  sel_ctrl;

  logic                   can_accept;
  logic                   push;
  logic                   pop;

  // Age is distance from the commit head modulo 2^RS_ID_WIDTH, so wrap needs no signed compare.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_age
    assign age[g] = in_rs_id_i[g*RS_ID_WIDTH +: RS_ID_WIDTH] - head_id_i;
  end

  // Pick the smallest-age valid channel; strict compare keeps the lowest index on ties.
  // Only the winning slice is copied, so unselected (possibly X) payloads never reach the queue.
  always_comb begin
    sel_any   = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    sel_rs_id = '0;
    sel_data  = '0;
    sel_ctrl  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_valid_i[c] && (!sel_any || (age[c] < sel_age))) begin
        sel_any   = 1'b1;
        sel_idx   = CH_W'(c);
        sel_age   = age[c];
        sel_rs_id = in_rs_id_i[c*RS_ID_WIDTH +: RS_ID_WIDTH];
        sel_data  = in_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        sel_ctrl  = in_ctrl_i[c*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end
  end

  // Space exists unless both entries are occupied; flush and reset also close the input side.
  assign can_accept = rst_ni && !flush_i && (state_q != ST_FULL);
  assign push       = sel_any && can_accept;
  assign pop        = out_valid_q && out_ready_i;

  // Grant only the winning channel so in_ready_o is one-hot or zero.
  always_comb begin
    in_ready_o = '0;
    if (sel_any && can_accept) begin
      in_ready_o[sel_idx] = 1'b1;
    end
  end

  // Queue FSM with registered head/skid payloads; flush empties it and drops any push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_EMPTY;
      out_valid_q    <= 1'b0;
      head_rs_id_q   <= '0;
      head_data_q    <= '0;
      head_ctrl_q    <= '0;
      head_channel_q <= '0;
      skid_rs_id_q   <= '0;
      skid_data_q    <= '0;
      skid_ctrl_q    <= '0;
      skid_channel_q <= '0;
    end else if (flush_i) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_q        <= ST_ONE;
            out_valid_q    <= 1'b1;
            head_rs_id_q   <= sel_rs_id;
            head_data_q    <= sel_data;
            head_ctrl_q    <= sel_ctrl;
            head_channel_q <= sel_idx;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            // Head stays put; newcomer waits behind it.
            state_q        <= ST_FULL;
            skid_rs_id_q   <= sel_rs_id;
            skid_data_q    <= sel_data;
            skid_ctrl_q    <= sel_ctrl;
            skid_channel_q <= sel_idx;
          end else if (pop && !push) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end else if (push && pop) begin
            // Head leaves this cycle, so the newcomer becomes head directly.
            head_rs_id_q   <= sel_rs_id;
            head_data_q    <= sel_data;
            head_ctrl_q    <= sel_ctrl;
            head_channel_q <= sel_idx;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_q        <= ST_ONE;
            head_rs_id_q   <= skid_rs_id_q;
            head_data_q    <= skid_data_q;
            head_ctrl_q    <= skid_ctrl_q;
            head_channel_q <= skid_channel_q;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_rs_id_o   = head_rs_id_q;
  assign out_data_o    = head_data_q;
  assign out_ctrl_o    = head_ctrl_q;
  assign out_channel_o = head_channel_q;

endmodule

// File: tb/tb_rs_age_arbiter.sv
// Bench for rs_age_arbiter: directed scenarios plus a randomized run against a queue model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// The model tracks queue contents as a list of entries and derives grants from modular age.
module tb_rs_age_arbiter;
  localparam int CH = 3;
  localparam int W  = 5;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int CHW = 2;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    head_id;
  logic            flush;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [CH*W-1:0] in_rs_id;
  logic [CH*DW-1:0] in_data;
  logic [CH*CW-1:0] in_ctrl;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_rs_id;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic [CHW-1:0]  out_channel;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0]   id;
    logic [DW-1:0]  data;
    logic [CW-1:0]  ctrl;
    logic [CHW-1:0] ch;
  } ent_t;

  rs_age_arbiter #(.CHANNELS(CH), .RS_ID_WIDTH(W), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .head_id_i(head_id), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_rs_id_i(in_rs_id),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_rs_id_o(out_rs_id), .out_data_o(out_data),
    .out_ctrl_o(out_ctrl), .out_channel_o(out_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] dat(int c, int id);
    return 32'hA500_0000 + DW'(c * 256) + DW'(id);
  endfunction

  task automatic set_ch(int c, bit v, int id);
    in_valid[c]           = v;
    in_rs_id[c*W +: W]    = W'(id);
    in_data[c*DW +: DW]   = dat(c, id);
    in_ctrl[c*CW +: CW]   = CW'(16'h3C00 + id);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; head_id = '0;
    in_valid = '0; in_rs_id = '0; in_data = '0; in_ctrl = '0;
    set_ch(0, 1'b1, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready_held: got %b expected 000", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_held: got %b expected 0", out_valid); end
    in_valid = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid c%0d: got %b expected 0", i, out_valid); end
      n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready c%0d: got %b expected 000", i, in_ready); end
      n_checks++; if ({out_rs_id, out_data, out_ctrl, out_channel} !== '0) begin n_fail++; $display("FAIL reset_out_fields c%0d: got id=%0d data=%h ctrl=%h ch=%0d expected all 0", i, out_rs_id, out_data, out_ctrl, out_channel); end
    end
    next_cycle();
  endtask

  task automatic test_basic();
    head_id = 5'd0; out_ready = 1'b1;
    set_ch(0, 1'b1, 7); set_ch(1, 1'b1, 3); set_ch(2, 1'b1, 12);
    @(negedge clk);
    n_checks++; if (in_ready !== 3'b010) begin n_fail++; $display("FAIL basic_grant0: got %b expected 010", in_ready); end
    next_cycle(); in_valid[1] = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_rs_id !== 5'd3 || out_channel !== 2'd1) begin n_fail++; $display("FAIL basic_out0: got v=%b id=%0d ch=%0d expected v=1 id=3 ch=1", out_valid, out_rs_id, out_channel); end
    n_checks++; if (out_data !== dat(1, 3)) begin n_fail++; $display("FAIL basic_data0: got %h expected %h", out_data, dat(1, 3)); end
    n_checks++; if (in_ready !== 3'b001) begin n_fail++; $display("FAIL basic_grant1: got %b expected 001", in_ready); end
    next_cycle(); in_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (out_rs_id !== 5'd7 || out_channel !== 2'd0) begin n_fail++; $display("FAIL basic_out1: got id=%0d ch=%0d expected id=7 ch=0", out_rs_id, out_channel); end
    n_checks++; if (in_ready !== 3'b100) begin n_fail++; $display("FAIL basic_grant2: got %b expected 100", in_ready); end
    next_cycle(); in_valid[2] = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_rs_id !== 5'd12 || out_channel !== 2'd2) begin n_fail++; $display("FAIL basic_out2: got v=%b id=%0d ch=%0d expected v=1 id=12 ch=2", out_valid, out_rs_id, out_channel); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b expected 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_wrap();
    head_id = 5'd30; out_ready = 1'b1;
    set_ch(0, 1'b1, 1); set_ch(1, 1'b1, 31); set_ch(2, 1'b0, 0);
    @(negedge clk);
    n_checks++; if (in_ready !== 3'b010) begin n_fail++; $display("FAIL wrap_grant0: got %b expected 010", in_ready); end
    next_cycle(); in_valid[1] = 1'b0;
    @(negedge clk);
    n_checks++; if (out_rs_id !== 5'd31 || out_channel !== 2'd1) begin n_fail++; $display("FAIL wrap_out0: got id=%0d ch=%0d expected id=31 ch=1", out_rs_id, out_channel); end
    n_checks++; if (in_ready !== 3'b001) begin n_fail++; $display("FAIL wrap_grant1: got %b expected 001", in_ready); end
    next_cycle(); in_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_rs_id !== 5'd1) begin n_fail++; $display("FAIL wrap_out1: got v=%b id=%0d expected v=1 id=1", out_valid, out_rs_id); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: got %b expected 0", out_valid); end
    next_cycle(); head_id = 5'd0;
  endtask

  task automatic test_backpressure();
    head_id = 5'd0; out_ready = 1'b0;
    set_ch(0, 1'b1, 4);
    @(negedge clk);
    n_checks++; if (in_ready !== 3'b001) begin n_fail++; $display("FAIL bp_grant0: got %b expected 001", in_ready); end
    next_cycle(); set_ch(0, 1'b1, 5);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_rs_id !== 5'd4 || in_ready !== 3'b001) begin n_fail++; $display("FAIL bp_cycle1: got v=%b id=%0d rdy=%b expected v=1 id=4 rdy=001", out_valid, out_rs_id, in_ready); end
    next_cycle(); set_ch(0, 1'b1, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 3'b000 || out_valid !== 1'b1 || out_rs_id !== 5'd4 || out_data !== dat(0, 4)) begin n_fail++; $display("FAIL bp_full_hold%0d: got rdy=%b v=%b id=%0d data=%h expected rdy=000 v=1 id=4 data=%h", i, in_ready, out_valid, out_rs_id, out_data, dat(0, 4)); end
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_rs_id !== 5'd4 || in_ready !== 3'b000) begin n_fail++; $display("FAIL bp_drain0: got id=%0d rdy=%b expected id=4 rdy=000", out_rs_id, in_ready); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_rs_id !== 5'd5 || in_ready !== 3'b001) begin n_fail++; $display("FAIL bp_drain1: got id=%0d rdy=%b expected id=5 rdy=001", out_rs_id, in_ready); end
    next_cycle(); in_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_rs_id !== 5'd6) begin n_fail++; $display("FAIL bp_drain2: got v=%b id=%0d expected v=1 id=6", out_valid, out_rs_id); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    head_id = 5'd0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ch(2, 1'b1, 20 + i);
      @(negedge clk);
      n_checks++; if (in_ready !== 3'b100) begin n_fail++; $display("FAIL b2b_grant%0d: got %b expected 100", i, in_ready); end
      if (i > 0) begin
        n_checks++; if (out_valid !== 1'b1 || out_rs_id !== W'(20 + i - 1)) begin n_fail++; $display("FAIL b2b_out%0d: got v=%b id=%0d expected v=1 id=%0d", i, out_valid, out_rs_id, 20 + i - 1); end
      end
      next_cycle();
    end
    in_valid[2] = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_rs_id !== 5'd29) begin n_fail++; $display("FAIL b2b_last: got v=%b id=%0d expected v=1 id=29", out_valid, out_rs_id); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_flush();
    head_id = 5'd0; out_ready = 1'b0;
    set_ch(0, 1'b1, 1);
    @(negedge clk); next_cycle();
    set_ch(0, 1'b1, 2);
    @(negedge clk); next_cycle();
    set_ch(0, 1'b1, 3);
    @(negedge clk);
    n_checks++; if (in_ready !== 3'b000 || out_rs_id !== 5'd1) begin n_fail++; $display("FAIL flush_full: got rdy=%b id=%0d expected rdy=000 id=1", in_ready, out_rs_id); end
    next_cycle();
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL flush_grant: got %b expected 000", in_ready); end
    next_cycle(); flush = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 3'b001) begin n_fail++; $display("FAIL flush_regrant: got %b expected 001", in_ready); end
    next_cycle(); in_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_rs_id !== 5'd3) begin n_fail++; $display("FAIL flush_after: got v=%b id=%0d expected v=1 id=3", out_valid, out_rs_id); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drained: got %b expected 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_mid_reset();
    head_id = 5'd0; out_ready = 1'b0;
    set_ch(1, 1'b1, 9);
    next_cycle(); next_cycle();
    in_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_rs_id !== 5'd0 || out_data !== '0 || out_channel !== 2'd0) begin n_fail++; $display("FAIL midrst_async: got v=%b id=%0d data=%h ch=%0d expected all 0", out_valid, out_rs_id, out_data, out_channel); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_after%0d: got v=%b rdy=%b expected v=0 rdy=000", i, out_valid, in_ready); end
    end
    next_cycle();
  endtask

  task automatic test_random();
    ent_t q[$];
    int best, best_age, age;
    logic [CH-1:0] exp_rdy;
    ent_t e;
    for (int n = 0; n < 3000; n++) begin
      head_id = W'($urandom_range(0, 31));
      for (int c = 0; c < CH; c++) begin
        in_valid[c]          = ($urandom_range(0, 2) != 0);
        in_rs_id[c*W +: W]   = W'($urandom_range(0, 31));
        in_data[c*DW +: DW]  = DW'($urandom);
        in_ctrl[c*CW +: CW]  = CW'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = (n == 0) || ($urandom_range(0, 40) == 0);
      best = -1; best_age = 0;
      for (int c = 0; c < CH; c++) begin
        if (in_valid[c]) begin
          age = (int'(in_rs_id[c*W +: W]) - int'(head_id) + 32) % 32;
          if (best < 0 || age < best_age) begin best = c; best_age = age; end
        end
      end
      exp_rdy = (best >= 0 && q.size() < 2 && !flush) ? CH'(1 << best) : '0;
      @(negedge clk);
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_grant n=%0d: got %b expected %b", n, in_ready, exp_rdy); end
      if (n > 0) begin
        n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_valid n=%0d: got %b expected %b", n, out_valid, q.size() != 0); end
        if (q.size() != 0) begin
          n_checks++; if (out_rs_id !== q[0].id || out_data !== q[0].data || out_ctrl !== q[0].ctrl || out_channel !== q[0].ch) begin n_fail++; $display("FAIL rand_head n=%0d: got id=%0d data=%h ctrl=%h ch=%0d expected id=%0d data=%h ctrl=%h ch=%0d", n, out_rs_id, out_data, out_ctrl, out_channel, q[0].id, q[0].data, q[0].ctrl, q[0].ch); end
        end
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (exp_rdy != '0) begin
          e.id = in_rs_id[best*W +: W]; e.data = in_data[best*DW +: DW];
          e.ctrl = in_ctrl[best*CW +: CW]; e.ch = CHW'(best);
          q.push_back(e);
        end
      end
      next_cycle();
    end
    in_valid = '0; flush = 1'b0; out_ready = 1'b1;
    next_cycle(); next_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_age_arbiter.md
Name: rs_age_arbiter

Overview:
- Parametrised N-channel merger that sits between a group of reservation stations and one shared execution unit.
- Each cycle it picks the oldest ready instruction across all channels. Age is wrap-aware: each RS ID is measured relative to a head ID supplied by the commit logic.
- The winner is buffered in a 2-entry registered skid queue. This gives full throughput and a registered output with no combinational ready path from output to input.
- Successor to the fixed 3-way smallest-ID mux. It adds channel count, wrap-around ordering, output registering, flush and a channel tag.

Parameters:
CHANNELS, 3, number of input channels (2..8)
RS_ID_WIDTH, 5, width of reservation-station IDs
DATA_WIDTH, 32, operand payload width
CTRL_WIDTH, 16, opaque packed control payload width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
head_id  in  RS_ID_WIDTH  oldest in-flight RS ID (commit head)
flush  in  1  synchronous discard of all buffered entries
in_valid  in  CHANNELS  per-channel valid
in_ready  out  CHANNELS  per-channel ready (one-hot or zero)
in_rs_id  in  CHANNELS*RS_ID_WIDTH  per-channel RS ID, channel c at slice c
in_data  in  CHANNELS*DATA_WIDTH  per-channel operand
in_ctrl  in  CHANNELS*CTRL_WIDTH  per-channel control
out_valid  out  1  output valid
out_ready  in  1  output ready
out_rs_id  out  RS_ID_WIDTH  RS ID of output entry
out_data  out  DATA_WIDTH  operand of output entry
out_ctrl  out  CTRL_WIDTH  control of output entry
out_channel  out  clog2(CHANNELS) (min 1)  source channel of output entry

Behaviour:
- Age of channel c = (in_rs_id[c] - head_id) mod 2^RS_ID_WIDTH, unsigned. Smaller age is older.
- Winner is the valid channel with the smallest age. On equal age, the lowest channel index wins.
- Selection is combinational on the current inputs only and is independent of buffer contents.
- Buffer: 2-entry FIFO, count in {0,1,2}. States are EMPTY, ONE and FULL.
- in_ready[winner] = 1 iff any in_valid, count<2 and flush=0. All other in_ready bits are 0.
- in_ready must not depend on out_ready.
- push = in_valid[winner] & in_ready[winner]. pop = out_valid & out_ready.
- Latency: a push in cycle t appears on the outputs in cycle t+1 when count was 0, or when count was 1 with a pop in cycle t.
- out_valid = (count != 0). All out_* fields come from the head entry and are registered; there is no combinational path from inputs to out_*.
- State transitions:
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop -> ONE, where the new entry becomes head next cycle.
  - FULL: pop -> ONE; push is impossible.
- Order: entries leave in push order. The arbiter does not reorder entries already buffered.
- flush=1: next cycle count=0, out_valid=0. Any pop or push in that cycle is ignored. The input side sees in_ready=0 during the flush cycle.
- Once accepted, output payload is held stable while out_valid=1 and out_ready=0.
- Reset (rst=0, asynchronous): count=0, out_valid=0, out_rs_id=0, out_data=0, out_ctrl=0, out_channel=0, in_ready=0.
  - Applies mid-operation; buffered entries are lost.
  - Output is clean from the first edge after release.
- Width rules:
  - in_valid with an RS ID equal to head_id has age 0, which is the highest priority.
  - Wrap is handled purely by modular subtraction; there are no signed compares.
- X-safety: unselected channel data is never captured.

Test Plan:
- Reset hold, then release with all in_valid=0 -> out_valid=0, in_ready=000, all out fields 0 for 5 cycles.
- CHANNELS=3, head_id=0, valid IDs ch0=7, ch1=3, ch2=12, out_ready=1:
  - Cycle 0: in_ready=010.
  - Next cycle: out_rs_id=3, out_channel=1.
  - Then IDs 7 (ch0), then 12 (ch2) on successive cycles.
- Wrap: head_id=30, ch0 ID=1, ch1 ID=31 -> ch1 wins first (age 1 vs 3), out_rs_id=31, then 1.
- Backpressure: out_ready=0 with continuous valid ch0 IDs 4,5,6 -> two pushes, count=2, in_ready=000 on the third cycle, out_rs_id stays 4. Raising out_ready drains 4 then 5, after which 6 is accepted.
- Simultaneous push/pop at count=1 at full rate -> one output per cycle, no bubbles over 10 back-to-back IDs; order is preserved.
- flush asserted while count=2 -> next cycle out_valid=0, count=0; an in_valid present during the flush cycle is not accepted (in_ready=0) and is accepted the following cycle.
